// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vend controller / chute / ejector and the change dispenser.
// The dispenser side uses the slave modport; the environment drives through master.
interface change_dispenser_if #(
    parameter int CNT_W = 6
);
    logic             vend_i;
    logic [2:0]       change_i;
    logic             soda_ack_i;
    logic             eject_ack_i;
    logic             load_i;
    logic [CNT_W-1:0] load_nickel_i;
    logic [CNT_W-1:0] load_dime_i;
    logic             soda_req_o;
    logic             nickel_req_o;
    logic             dime_req_o;
    logic             busy_o;
    logic             done_o;
    logic             short_o;
    logic             overrun_o;
    logic             err_o;
    logic [CNT_W-1:0] nickel_cnt_o;
    logic [CNT_W-1:0] dime_cnt_o;

    modport master (
        output vend_i, change_i, soda_ack_i, eject_ack_i, load_i, load_nickel_i, load_dime_i,
        input  soda_req_o, nickel_req_o, dime_req_o, busy_o, done_o, short_o, overrun_o,
               err_o, nickel_cnt_o, dime_cnt_o
    );

    modport slave (
        input  vend_i, change_i, soda_ack_i, eject_ack_i, load_i, load_nickel_i, load_dime_i,
        output soda_req_o, nickel_req_o, dime_req_o, busy_o, done_o, short_o, overrun_o,
               err_o, nickel_cnt_o, dime_cnt_o
    );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: releases a soda, then pays change greedily in dimes and nickels
// from a loadable coin inventory, short-paying when the inventory runs out.
module change_dispenser #(
    parameter int CNT_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    change_dispenser_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SODA   = 3'd1;
    localparam logic [2:0] ST_PLAN   = 3'd2;
    localparam logic [2:0] ST_DIME   = 3'd3;
    localparam logic [2:0] ST_NICKEL = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic             short_q, short_d;
    logic [CNT_W-1:0] nickel_cnt_q, nickel_cnt_d;
    logic [CNT_W-1:0] dime_cnt_q, dime_cnt_d;
    logic             overrun_q, overrun_d;
    logic             err_q, err_d;
    logic             code_valid;

    assign code_valid = (bus.change_i <= 3'd4);

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        short_d      = short_q;
        nickel_cnt_d = nickel_cnt_q;
        dime_cnt_d   = dime_cnt_q;
        // Only a vend that is actually accepted can flag a bad change code.
        overrun_d    = bus.vend_i && (state_q != ST_IDLE);
        err_d        = bus.vend_i && (state_q == ST_IDLE) && !code_valid;

        case (state_q)
            ST_IDLE: begin
                if (bus.vend_i) begin
                    rem_d   = code_valid ? bus.change_i : 3'd0;
                    short_d = 1'b0;
                    state_d = ST_SODA;
                end else if (bus.load_i) begin
                    nickel_cnt_d = bus.load_nickel_i;
                    dime_cnt_d   = bus.load_dime_i;
                end
            end
            ST_SODA: begin
                if (bus.soda_ack_i) begin
                    state_d = ST_PLAN;
                end
            end
            ST_PLAN: begin
                // Dimes first; a zero-count check here is what keeps the counters from wrapping.
                if ((rem_q >= 3'd2) && (dime_cnt_q != '0)) begin
                    state_d = ST_DIME;
                end else if ((rem_q >= 3'd1) && (nickel_cnt_q != '0)) begin
                    state_d = ST_NICKEL;
                end else if (rem_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DIME: begin
                if (bus.eject_ack_i) begin
                    rem_d      = rem_q - 3'd2;
                    dime_cnt_d = dime_cnt_q - 1'b1;
                    state_d    = ST_PLAN;
                end
            end
            ST_NICKEL: begin
                if (bus.eject_ack_i) begin
                    rem_d        = rem_q - 3'd1;
                    nickel_cnt_d = nickel_cnt_q - 1'b1;
                    state_d      = ST_PLAN;
                end
            end
            ST_DONE: begin
                short_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rem_q        <= 3'd0;
            short_q      <= 1'b0;
            nickel_cnt_q <= '0;
            dime_cnt_q   <= '0;
            overrun_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            short_q      <= short_d;
            nickel_cnt_q <= nickel_cnt_d;
            dime_cnt_q   <= dime_cnt_d;
            overrun_q    <= overrun_d;
            err_q        <= err_d;
        end
    end

    assign bus.soda_req_o   = (state_q == ST_SODA);
    assign bus.dime_req_o   = (state_q == ST_DIME);
    assign bus.nickel_req_o = (state_q == ST_NICKEL);
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.done_o       = (state_q == ST_DONE);
    assign bus.short_o      = (state_q == ST_DONE) && short_q;
    assign bus.overrun_o    = overrun_q;
    assign bus.err_o        = err_q;
    assign bus.nickel_cnt_o = nickel_cnt_q;
    assign bus.dime_cnt_o   = dime_cnt_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, randomized transactions
// against a coin-arithmetic reference model, and hand-written corner sequences.
module tb_change_dispenser;
    localparam int CNT_W = 6;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    change_dispenser_if #(.CNT_W(CNT_W)) bus ();

    change_dispenser #(.CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         load_n;
        int         load_d;
        logic [2:0] code;
        int         exp_dimes;
        int         exp_nickels;
        int         exp_short;
        int         exp_err;
        int         exp_n_after;
        int         exp_d_after;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_load(input int n, input int d);
        bus.load_i        = 1'b1;
        bus.load_nickel_i = CNT_W'(n);
        bus.load_dime_i   = CNT_W'(d);
        @(negedge clk);
        bus.load_i = 1'b0;
    endtask

    // Issues a vend strobe and stops at the cycle where the soda request must already be up.
    task automatic apply_stimulus(input logic [2:0] code, output int err_seen);
        bus.vend_i   = 1'b1;
        bus.change_i = code;
        @(negedge clk);
        bus.vend_i   = 1'b0;
        bus.change_i = 3'd0;
        err_seen     = int'(bus.err_o);
        check_output("soda_latency", int'(bus.soda_req_o), 1);
    endtask

    // Services outstanding requests with random ack delays until done_o, noting what was paid.
    task automatic service(input int max_delay, output int sodas, output int dimes,
                           output int nickels, output int short_seen, output int done_seen,
                           output int order_ok);
        int delay;
        int wait_cnt;
        int budget;
        sodas = 0; dimes = 0; nickels = 0; short_seen = 0; done_seen = 0; order_ok = 1;
        delay = $urandom_range(0, max_delay);
        wait_cnt = 0;
        budget = 0;
        while (done_seen == 0 && budget < 200) begin
            bus.soda_ack_i  = 1'b0;
            bus.eject_ack_i = 1'b0;
            if ((int'(bus.soda_req_o) + int'(bus.dime_req_o) + int'(bus.nickel_req_o)) > 1)
                order_ok = 0;
            if (bus.dime_req_o && nickels > 0) order_ok = 0;
            if (bus.done_o) begin
                done_seen  = 1;
                short_seen = int'(bus.short_o);
            end else if (bus.soda_req_o) begin
                if (wait_cnt >= delay) begin
                    bus.soda_ack_i = 1'b1;
                    sodas++;
                    delay = $urandom_range(0, max_delay);
                    wait_cnt = 0;
                end else begin
                    bus.eject_ack_i = 1'($urandom % 2);
                    wait_cnt++;
                end
            end else if (bus.dime_req_o || bus.nickel_req_o) begin
                if (wait_cnt >= delay) begin
                    bus.eject_ack_i = 1'b1;
                    if (bus.dime_req_o) dimes++;
                    else nickels++;
                    delay = $urandom_range(0, max_delay);
                    wait_cnt = 0;
                end else begin
                    bus.soda_ack_i = 1'($urandom % 2);
                    wait_cnt++;
                end
            end
            @(negedge clk);
            budget++;
        end
        bus.soda_ack_i  = 1'b0;
        bus.eject_ack_i = 1'b0;
    endtask

    task automatic check_txn(input string tag, input int sodas, input int dimes, input int nickels,
                             input int short_seen, input int done_seen, input int order_ok,
                             input int err_seen, input vec_t v);
        check_output({tag, "_done"}, done_seen, 1);
        check_output({tag, "_sodas"}, sodas, 1);
        check_output({tag, "_dimes"}, dimes, v.exp_dimes);
        check_output({tag, "_nickels"}, nickels, v.exp_nickels);
        check_output({tag, "_short"}, short_seen, v.exp_short);
        check_output({tag, "_err"}, err_seen, v.exp_err);
        check_output({tag, "_order"}, order_ok, 1);
        check_output({tag, "_ncnt"}, int'(bus.nickel_cnt_o), v.exp_n_after);
        check_output({tag, "_dcnt"}, int'(bus.dime_cnt_o), v.exp_d_after);
        check_output({tag, "_idle"}, int'(bus.busy_o), 0);
    endtask

    // Reference model: change owed in 5c units, dimes as many as fit, nickels fill the rest.
    function automatic vec_t model(input int n, input int d, input logic [2:0] code);
        vec_t v;
        int owed;
        int left;
        owed = (code <= 3'd4) ? int'(code) : 0;
        v.load_n      = n;
        v.load_d      = d;
        v.code        = code;
        v.exp_dimes   = (d < owed / 2) ? d : owed / 2;
        left          = owed - 2 * v.exp_dimes;
        v.exp_nickels = (n < left) ? n : left;
        v.exp_short   = (left > v.exp_nickels) ? 1 : 0;
        v.exp_err     = (code > 3'd4) ? 1 : 0;
        v.exp_n_after = n - v.exp_nickels;
        v.exp_d_after = d - v.exp_dimes;
        return v;
    endfunction

    initial begin
        int sodas, dimes, nickels, short_seen, done_seen, order_ok, err_seen;
        int cur_n, cur_d;
        vec_t v;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.vend_i = 1'b0; bus.change_i = 3'd0; bus.soda_ack_i = 1'b0; bus.eject_ack_i = 1'b0;
        bus.load_i = 1'b0; bus.load_nickel_i = '0; bus.load_dime_i = '0;

        vecs[0] = '{5, 3, 3'b011, 1, 1, 0, 0, 4, 2};
        vecs[1] = '{4, 0, 3'b100, 0, 4, 0, 0, 0, 0};
        vecs[2] = '{0, 2, 3'b011, 1, 0, 1, 0, 0, 1};
        vecs[3] = '{3, 3, 3'b101, 0, 0, 0, 1, 3, 3};
        vecs[4] = '{2, 2, 3'b000, 0, 0, 0, 0, 2, 2};
        vecs[5] = '{1, 1, 3'b100, 1, 1, 1, 0, 0, 0};
        vecs[6] = '{0, 0, 3'b001, 0, 0, 1, 0, 0, 0};
        vecs[7] = '{1, 0, 3'b010, 0, 1, 1, 0, 0, 0};

        @(negedge clk);
        do_reset();
        check_output("rst_busy", int'(bus.busy_o), 0);
        check_output("rst_reqs", int'(bus.soda_req_o) + int'(bus.dime_req_o) + int'(bus.nickel_req_o), 0);
        check_output("rst_done", int'(bus.done_o), 0);
        check_output("rst_ncnt", int'(bus.nickel_cnt_o), 0);
        check_output("rst_dcnt", int'(bus.dime_cnt_o), 0);

        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].load_n, vecs[i].load_d);
            apply_stimulus(vecs[i].code, err_seen);
            service(0, sodas, dimes, nickels, short_seen, done_seen, order_ok);
            @(negedge clk);
            check_txn($sformatf("vec%0d", i), sodas, dimes, nickels, short_seen, done_seen,
                      order_ok, err_seen, vecs[i]);
        end

        cur_n = 0;
        cur_d = 0;
        for (int i = 0; i < 40; i++) begin
            if ((i == 0) || ($urandom % 2 == 1)) begin
                cur_n = $urandom_range(0, 5);
                cur_d = $urandom_range(0, 3);
                do_load(cur_n, cur_d);
            end
            v = model(cur_n, cur_d, 3'($urandom_range(0, 7)));
            apply_stimulus(v.code, err_seen);
            service(3, sodas, dimes, nickels, short_seen, done_seen, order_ok);
            @(negedge clk);
            check_txn($sformatf("rnd%0d", i), sodas, dimes, nickels, short_seen, done_seen,
                      order_ok, err_seen, v);
            cur_n = v.exp_n_after;
            cur_d = v.exp_d_after;
        end

        // Second vend while the soda is still pending must be flagged and dropped.
        do_load(5, 3);
        apply_stimulus(3'b010, err_seen);
        bus.vend_i   = 1'b1;
        bus.change_i = 3'b100;
        @(negedge clk);
        bus.vend_i   = 1'b0;
        bus.change_i = 3'd0;
        check_output("ovr_pulse", int'(bus.overrun_o), 1);
        check_output("ovr_soda_held", int'(bus.soda_req_o), 1);
        service(1, sodas, dimes, nickels, short_seen, done_seen, order_ok);
        @(negedge clk);
        check_txn("ovr", sodas, dimes, nickels, short_seen, done_seen, order_ok, err_seen,
                  model(5, 3, 3'b010));
        @(negedge clk);
        check_output("ovr_no_second", int'(bus.busy_o), 0);
        check_output("ovr_pulse_gone", int'(bus.overrun_o), 0);

        // Reset asserted in the middle of a dime ejection.
        do_load(5, 3);
        apply_stimulus(3'b011, err_seen);
        bus.soda_ack_i = 1'b1;
        @(negedge clk);
        bus.soda_ack_i = 1'b0;
        check_output("plan_quiet", int'(bus.soda_req_o) + int'(bus.dime_req_o) + int'(bus.nickel_req_o), 0);
        @(negedge clk);
        check_output("mid_dime_req", int'(bus.dime_req_o), 1);
        do_reset();
        check_output("mid_rst_reqs", int'(bus.soda_req_o) + int'(bus.dime_req_o) + int'(bus.nickel_req_o), 0);
        check_output("mid_rst_busy", int'(bus.busy_o), 0);
        check_output("mid_rst_ncnt", int'(bus.nickel_cnt_o), 0);
        check_output("mid_rst_dcnt", int'(bus.dime_cnt_o), 0);

        // Load coinciding with vend is ignored; the transaction pays from the old inventory.
        do_load(2, 2);
        bus.load_i        = 1'b1;
        bus.load_nickel_i = CNT_W'(7);
        bus.load_dime_i   = CNT_W'(7);
        apply_stimulus(3'b011, err_seen);
        bus.load_i = 1'b0;
        service(0, sodas, dimes, nickels, short_seen, done_seen, order_ok);
        @(negedge clk);
        check_txn("ldvend", sodas, dimes, nickels, short_seen, done_seen, order_ok, err_seen,
                  model(2, 2, 3'b011));

        // Load while a dime is being requested is ignored.
        do_load(4, 4);
        apply_stimulus(3'b100, err_seen);
        bus.soda_ack_i = 1'b1;
        @(negedge clk);
        bus.soda_ack_i = 1'b0;
        @(negedge clk);
        bus.load_i        = 1'b1;
        bus.load_nickel_i = CNT_W'(9);
        bus.load_dime_i   = CNT_W'(9);
        @(negedge clk);
        bus.load_i = 1'b0;
        check_output("lddime_ncnt", int'(bus.nickel_cnt_o), 4);
        check_output("lddime_dcnt", int'(bus.dime_cnt_o), 4);
        service(0, sodas, dimes, nickels, short_seen, done_seen, order_ok);
        @(negedge clk);
        check_output("lddime_done", done_seen, 1);
        check_output("lddime_dimes", dimes, 2);
        check_output("lddime_nickels", nickels, 0);
        check_output("lddime_short", short_seen, 0);
        check_output("lddime_ncnt_end", int'(bus.nickel_cnt_o), 4);
        check_output("lddime_dcnt_end", int'(bus.dime_cnt_o), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
